uart_icb_master: RTL and testbench



---
 rtl/uart_icb_master_pkg.sv | 59 +++++
 rtl/uart_icb_master_if.sv | 24 ++
 rtl/uart_icb_master_port.sv | 45 ++++
 rtl/uart_icb_master.sv | 147 ++++++++++++++
 tb/tb_uart_icb_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_icb_master_pkg.sv
// rtl/uart_icb_master_pkg.sv - shared constants, state encoding and command type for the UART ICB master
package uart_icb_master_pkg;

  localparam int PA_SIZE = 32;

  // UART register map
  localparam logic [PA_SIZE-1:0] BASE_ADDR = 32'h1001_3000;
  localparam logic [PA_SIZE-1:0] CSR_OFS   = 32'h0;
  localparam logic [PA_SIZE-1:0] CTRL_OFS  = 32'h4;
  localparam logic [PA_SIZE-1:0] DATA_OFS  = 32'h8;

  // CSR bit positions
  localparam int CSR_TX_OK   = 0;
  localparam int CSR_RX_OK   = 4;
  localparam int CSR_DIV_LSB = 16;

  // CTRL bit positions
  localparam int CTRL_BAUD_EN   = 0;
  localparam int CTRL_TX_EN     = 4;
  localparam int CTRL_RX_EN     = 8;
  localparam int CTRL_CLK_EN    = 9;
  localparam int CTRL_NO_PARITY = 12;

  localparam logic [15:0] DIVISOR = 16'd54;

  // Divisor lands in CSR[31:16]; the low half is written as zero
  localparam logic [PA_SIZE-1:0] CSR_INIT = {16'h0000, DIVISOR} << CSR_DIV_LSB;

  localparam logic [PA_SIZE-1:0] CTRL_INIT = (32'h1 << CTRL_BAUD_EN) | (32'h1 << CTRL_TX_EN)
                                           | (32'h1 << CTRL_RX_EN)   | (32'h1 << CTRL_CLK_EN)
                                           | (32'h1 << CTRL_NO_PARITY);

  typedef enum logic [2:0] {
    S_RST,
    S_INIT_CSR,
    S_INIT_CTRL,
    S_IDLE,
    S_POLL,
    S_WR_DATA,
    S_RD_DATA
  } state_t;

  typedef struct packed {
    logic [PA_SIZE-1:0] addr;
    logic               read;
    logic [PA_SIZE-1:0] wdata;
  } icb_cmd_t;

  // Builds a bus command for a register offset inside the UART window
  function automatic icb_cmd_t make_cmd(input logic [PA_SIZE-1:0] ofs, input logic read,
                                        input logic [PA_SIZE-1:0] wdata);
    icb_cmd_t c;
    c.addr  = BASE_ADDR + ofs;
    c.read  = read;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/uart_icb_master_if.sv
// rtl/uart_icb_master_if.sv - ICB command/response bus between the master and the UART slave port
interface uart_icb_master_if;
  import uart_icb_master_pkg::*;

  logic               o_icb_cmd_valid;
  logic               o_icb_cmd_ready;
  logic [PA_SIZE-1:0] o_icb_cmd_addr;
  logic               o_icb_cmd_read;
  logic [PA_SIZE-1:0] o_icb_cmd_wdata;
  logic               o_icb_rsp_valid;
  logic               o_icb_rsp_ready;
  logic [PA_SIZE-1:0] o_icb_rsp_rdata;

  modport master (
    output o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata, o_icb_rsp_ready,
    input  o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata
  );

  modport slave (
    input  o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata, o_icb_rsp_ready,
    output o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata
  );

endinterface

// File: rtl/uart_icb_master_port.sv
// rtl/uart_icb_master_port.sv - CMD/RSP phase sequencer for one outstanding ICB transaction
module uart_icb_master_port
  import uart_icb_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  icb_cmd_t           cmd,
  output logic               done,
  output logic [PA_SIZE-1:0] rdata,
  uart_icb_master_if.master  bus
);

  logic cmd_hold;
  logic rsp_phase;
  logic cmd_fire;

  // req is a one-cycle pulse from the FSM in the first CMD cycle; cmd_hold keeps valid up
  // under wait states. cmd fields come straight from the FSM's registers, which stay put
  // until the transaction is done.
  assign bus.o_icb_cmd_valid = req | cmd_hold;
  assign bus.o_icb_cmd_addr  = cmd.addr;
  assign bus.o_icb_cmd_read  = cmd.read;
  assign bus.o_icb_cmd_wdata = cmd.wdata;
  assign bus.o_icb_rsp_ready = rsp_phase;

  assign cmd_fire = bus.o_icb_cmd_valid & bus.o_icb_cmd_ready;
  assign done     = rsp_phase & bus.o_icb_rsp_valid;
  assign rdata    = bus.o_icb_rsp_rdata;

  // Hold the command valid from the request until the slave accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cmd_hold <= 1'b0;
    else if (cmd_fire) cmd_hold <= 1'b0;
    else if (req)      cmd_hold <= 1'b1;
  end

  // RSP phase runs from the accepted command until the response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rsp_phase <= 1'b0;
    else if (cmd_fire) rsp_phase <= 1'b1;
    else if (done)     rsp_phase <= 1'b0;
  end

endmodule

// File: rtl/uart_icb_master.sv
// rtl/uart_icb_master.sv - UART init, status polling and byte transfer over ICB
module uart_icb_master
  import uart_icb_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  uart_icb_master_if.master bus,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        rx_data,
  output logic              init_done
);

  state_t             state;
  logic               req;
  icb_cmd_t           cmd;
  logic               done;
  logic [PA_SIZE-1:0] rdata;
  logic               tx_armed;
  logic               tx_full;
  logic [7:0]         tx_byte;
  logic               rx_full;
  logic               tx_ok;
  logic               rx_ok;
  logic               unused_rdata;

  assign tx_ok        = rdata[CSR_TX_OK];
  assign rx_ok        = rdata[CSR_RX_OK];
  assign unused_rdata = ^rdata[PA_SIZE-1:8];
  assign tx_ready     = ~tx_full;
  assign rx_valid     = rx_full;

  uart_icb_master_port u_port (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .cmd   (cmd),
    .done  (done),
    .rdata (rdata),
    .bus   (bus)
  );

  // Main sequencer: init writes, then idle/poll loop; each bus state launches its command on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      req       <= 1'b0;
      cmd       <= '0;
      init_done <= 1'b0;
      tx_armed  <= 1'b1;
    end else begin
      req <= 1'b0;
      case (state)
        S_RST: begin
          if (en) begin
            state <= S_INIT_CSR;
            req   <= 1'b1;
            cmd   <= make_cmd(CSR_OFS, 1'b0, CSR_INIT);
          end
        end
        S_INIT_CSR: begin
          if (done) begin
            if (en) begin
              state <= S_INIT_CTRL;
              req   <= 1'b1;
              cmd   <= make_cmd(CTRL_OFS, 1'b0, CTRL_INIT);
            end else begin
              // init is restarted from the top once en returns
              state <= S_RST;
            end
          end
        end
        S_INIT_CTRL: begin
          if (done) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (en) begin
            state <= S_POLL;
            req   <= 1'b1;
            cmd   <= make_cmd(CSR_OFS, 1'b1, '0);
          end
        end
        S_POLL: begin
          if (done) begin
            // a poll with tx_ok low proves the previous byte has left the holding slot
            if (!tx_ok) tx_armed <= 1'b1;
            if (en && rx_ok && !rx_full) begin
              state <= S_RD_DATA;
              req   <= 1'b1;
              cmd   <= make_cmd(DATA_OFS, 1'b1, '0);
            end else if (en && tx_full && tx_ok && tx_armed) begin
              state <= S_WR_DATA;
              req   <= 1'b1;
              cmd   <= make_cmd(DATA_OFS, 1'b0, {24'h0, tx_byte});
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_WR_DATA: begin
          if (done) begin
            tx_armed <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_RD_DATA: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_RST;
      endcase
    end
  end

  // tx holding slot: filled from the stream whenever empty, emptied by the DATA write response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full <= 1'b0;
      tx_byte <= 8'h00;
    end else if (tx_valid && !tx_full) begin
      tx_full <= 1'b1;
      tx_byte <= tx_data;
    end else if (state == S_WR_DATA && done) begin
      tx_full <= 1'b0;
    end
  end

  // rx holding slot: loaded by the DATA read response, drained by the consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else if (state == S_RD_DATA && done) begin
      rx_full <= 1'b1;
      rx_data <= rdata[7:0];
    end else if (rx_full && rx_ready) begin
      rx_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_icb_master.sv
// tb/tb_uart_icb_master.sv - scoreboard bench for uart_icb_master with a scripted ICB slave
module tb_uart_icb_master;

  typedef struct {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
  } txn_t;

  localparam logic [31:0] A_CSR  = 32'h1001_3000;
  localparam logic [31:0] A_CTRL = 32'h1001_3004;
  localparam logic [31:0] A_DATA = 32'h1001_3008;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       init_done;

  uart_icb_master_if bus();

  uart_icb_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  txn_t        exp_q[$];
  logic [7:0]  rx_exp_q[$];
  logic [31:0] csr_q[$];
  logic [31:0] csr_default = 32'h0;
  logic [31:0] data_rd_val = 32'h0;
  int          cmd_wait = 0;
  int          rsp_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic r, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.read = r; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // ---------------- scripted ICB slave ----------------
  int          s_phase = 0;
  int          s_cnt   = 0;
  logic [31:0] s_addr  = 32'h0;
  logic        s_read  = 1'b0;

  initial begin
    bus.o_icb_cmd_ready = 1'b0;
    bus.o_icb_rsp_valid = 1'b0;
    bus.o_icb_rsp_rdata = 32'h0;
  end

  task automatic slave_step();
    if (!rst_n) begin
      s_phase = 0; s_cnt = 0;
      bus.o_icb_cmd_ready = 1'b0;
      bus.o_icb_rsp_valid = 1'b0;
      return;
    end
    if (s_phase == 1) begin
      bus.o_icb_cmd_ready = 1'b0; s_cnt = 0; s_phase = 3;
    end else if (s_phase == 2) begin
      bus.o_icb_rsp_valid = 1'b0; s_cnt = 0; s_phase = 0;
    end
    if (s_phase == 3) begin
      if (s_cnt >= rsp_wait) begin
        if (s_read && s_addr == A_CSR)
          bus.o_icb_rsp_rdata = (csr_q.size() > 0) ? csr_q.pop_front() : csr_default;
        else if (s_read && s_addr == A_DATA)
          bus.o_icb_rsp_rdata = data_rd_val;
        else
          bus.o_icb_rsp_rdata = 32'h0;
        bus.o_icb_rsp_valid = 1'b1;
        s_phase = 2;
      end else begin
        s_cnt++;
      end
    end else if (s_phase == 0 && bus.o_icb_cmd_valid) begin
      if (s_cnt >= cmd_wait) begin
        bus.o_icb_cmd_ready = 1'b1;
        s_addr = bus.o_icb_cmd_addr;
        s_read = bus.o_icb_cmd_read;
        s_phase = 1;
      end else begin
        s_cnt++;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    slave_step();
  end

  // ---------------- monitor / scoreboard ----------------
  logic        hold_active = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_read;
  logic [31:0] cur_addr = 32'h0;
  logic        cur_read = 1'b0;
  logic        chk_init_next = 1'b0;

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      hold_active = 1'b0;
      chk_init_next = 1'b0;
      continue;
    end
    if (chk_init_next) begin
      chk("init_done_after_ctrl_rsp", {31'h0, init_done}, 32'h1);
      chk_init_next = 1'b0;
    end
    if (bus.o_icb_cmd_valid) begin
      if (hold_active) begin
        n_vec++;
        if (bus.o_icb_cmd_addr !== h_addr || bus.o_icb_cmd_read !== h_read || bus.o_icb_cmd_wdata !== h_wdata) begin
          n_miss++;
          $display("FAIL cmd_stable: got addr=%08h read=%0b wdata=%08h, want addr=%08h read=%0b wdata=%08h",
                   bus.o_icb_cmd_addr, bus.o_icb_cmd_read, bus.o_icb_cmd_wdata, h_addr, h_read, h_wdata);
        end
      end else begin
        h_addr = bus.o_icb_cmd_addr; h_read = bus.o_icb_cmd_read; h_wdata = bus.o_icb_cmd_wdata;
        hold_active = 1'b1;
      end
      if (bus.o_icb_cmd_ready) begin
        hold_active = 1'b0;
        cur_addr = bus.o_icb_cmd_addr;
        cur_read = bus.o_icb_cmd_read;
        if (!(cur_read && cur_addr == A_CSR)) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_txn: got addr=%08h read=%0b wdata=%08h, want none",
                     bus.o_icb_cmd_addr, bus.o_icb_cmd_read, bus.o_icb_cmd_wdata);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            if (bus.o_icb_cmd_addr !== e.addr || bus.o_icb_cmd_read !== e.read || bus.o_icb_cmd_wdata !== e.wdata) begin
              n_miss++;
              $display("FAIL bus_txn: got addr=%08h read=%0b wdata=%08h, want addr=%08h read=%0b wdata=%08h",
                       bus.o_icb_cmd_addr, bus.o_icb_cmd_read, bus.o_icb_cmd_wdata, e.addr, e.read, e.wdata);
            end
          end
        end
      end
    end else if (hold_active) begin
      n_vec++; n_miss++;
      $display("FAIL cmd_valid_dropped: got valid=0, want valid=1 until accepted");
      hold_active = 1'b0;
    end
    if (bus.o_icb_rsp_valid && bus.o_icb_rsp_ready && cur_addr == A_CTRL && !cur_read) begin
      chk("init_done_during_ctrl_rsp", {31'h0, init_done}, 32'h0);
      chk_init_next = 1'b1;
    end
    if (rx_valid && rx_ready) begin
      n_vec++;
      if (rx_exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_rx: got 0x%02h, want none", rx_data);
      end else begin
        logic [7:0] eb;
        eb = rx_exp_q.pop_front();
        if (rx_data !== eb) begin
          n_miss++;
          $display("FAIL rx_byte: got 0x%02h, want 0x%02h", rx_data, eb);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_exp(input string name, input int limit);
    int i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, exp_q.size(), 32'h0);
  endtask

  task automatic wait_init(input string name, input int limit);
    int i = 0;
    while (!init_done && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'h0, init_done}, 32'h1);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    chk("tx_ready_before_push", {31'h0, tx_ready}, 32'h1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_after_push", {31'h0, tx_ready}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, {31'h0, bus.o_icb_cmd_valid}, 32'h0);
    chk({tag, "_rsp_ready"}, {31'h0, bus.o_icb_rsp_ready}, 32'h0);
    chk({tag, "_init_done"}, {31'h0, init_done}, 32'h0);
    chk({tag, "_rx_valid"},  {31'h0, rx_valid}, 32'h0);
    chk({tag, "_rx_data"},   {24'h0, rx_data}, 32'h0);
    chk({tag, "_tx_ready"},  {31'h0, tx_ready}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  i;
    logic found;

    // reset state, then hold en low: no bus activity
    tick(2); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("idle_without_en", {31'h0, bus.o_icb_cmd_valid}, 32'h0);

    // init: CSR = 0x0036_0000, CTRL = 0x0000_1311
    push_exp(A_CSR,  1'b0, 32'h0036_0000);
    push_exp(A_CTRL, 1'b0, 32'h0000_1311);
    en = 1'b1;
    wait_init("init_done_set", 60);
    wait_exp("init_txns_done", 20);
    tick(10);

    // tx: one write, then no second write while tx_ok never drops
    push_tx(8'hA5);
    push_exp(A_DATA, 1'b0, 32'h0000_00A5);
    csr_default = 32'h1;
    wait_exp("tx_a5_written", 60);
    tick(20);
    push_tx(8'h5A);
    tick(40);
    chk("tx_held_until_rearm", {31'h0, tx_ready}, 32'h0);
    push_exp(A_DATA, 1'b0, 32'h0000_005A);
    csr_q.push_back(32'h0);
    wait_exp("tx_5a_after_rearm", 60);
    csr_default = 32'h0;
    tick(10);

    // rx: one DATA read, then back-pressure blocks further reads
    data_rd_val = 32'h0000_003C;
    push_exp(A_DATA, 1'b1, 32'h0);
    rx_exp_q.push_back(8'h3C);
    csr_default = 32'h10;
    wait_exp("rx_data_read", 60);
    tick(30);
    chk("rx_valid_held", {31'h0, rx_valid}, 32'h1);
    chk("rx_data_held", {24'h0, rx_data}, 32'h3C);
    csr_default = 32'h0;
    tick(10);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    tick(2);
    chk("rx_drained", rx_exp_q.size(), 32'h0);

    // priority: CSR=0x11 with tx pending and rx empty -> read before write
    push_tx(8'h77);
    tick(10);
    data_rd_val = 32'h0000_0099;
    push_exp(A_DATA, 1'b1, 32'h0);
    push_exp(A_DATA, 1'b0, 32'h0000_0077);
    rx_exp_q.push_back(8'h99);
    csr_q.push_back(32'h11);
    csr_q.push_back(32'h11);
    wait_exp("priority_rd_then_wr", 80);
    tick(10);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    tick(2);
    chk("priority_rx_drained", rx_exp_q.size(), 32'h0);

    // wait states on both channels
    cmd_wait = 5;
    rsp_wait = 3;
    tick(30);
    push_tx(8'hC3);
    push_exp(A_DATA, 1'b0, 32'h0000_00C3);
    csr_q.push_back(32'h1);
    wait_exp("waitstate_write", 300);
    tick(40);
    rsp_wait = 0;

    // reset during the DATA write command phase
    cmd_wait = 30;
    tick(40);
    push_tx(8'hE1);
    csr_q.push_back(32'h1);
    found = 1'b0;
    i = 0;
    while (i < 400) begin
      @(negedge clk); #1;
      if (bus.o_icb_cmd_valid && bus.o_icb_cmd_addr == A_DATA && !bus.o_icb_cmd_read) begin
        found = 1'b1;
        break;
      end
      i++;
    end
    chk("wr_cmd_seen_before_reset", {31'h0, found}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    cmd_wait = 0;
    csr_q.delete();
    push_exp(A_CSR,  1'b0, 32'h0036_0000);
    push_exp(A_CTRL, 1'b0, 32'h0000_1311);
    tick(3);
    rst_n = 1'b1;
    wait_init("reinit_done", 60);
    wait_exp("reinit_txns_done", 20);
    tick(20);

    chk("exp_queue_empty", exp_q.size(), 32'h0);
    chk("rx_queue_empty", rx_exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of sequence, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
